truth_table_prober: RTL and testbench
=====================================

# truth_table_prober

Sequential stimulus/capture engine that drives the four inputs of a combinational 4-input gate-level circuit and reads back its single output. It sweeps all 16 input rows, waits a settle interval per row, samples the response, and assembles the 16-bit hex truth table, such as 0x70EC. It also compares the table against an expected value. It sits on the test side of each circuit netlist: the circuit is the responder, and this block is the initiator and reader.

## Interface
Parameters:
- SETTLE_CYCLES, 4, number of cycles in SETTLE per row; legal range 3..255
- EXPECTED, 16'h70EC, expected truth table in the codebase hex convention

Ports:
- clk  input  1  single clock
- rst_n  input  1  reset; **synchronous, active-low**
- start  input  1  request a sweep; honoured only in IDLE
- dut_out  input  1  circuit output; may be asynchronous to clk
- drive_in1, drive_in2, drive_in3, drive_in4  output  1 each  circuit inputs
- busy  output  1  high in SETTLE and CAPTURE
- done  output  1  one-cycle pulse when the sweep completes
- tt  output  16  captured truth table
- pass  output  1  tt == EXPECTED, valid from done and held until next start
- fail_row  output  4  lowest row index whose captured bit differs from EXPECTED; 0 when pass

## Operation
- Row index r (4 bits) maps to inputs as {in1,in2,in3,in4} = r, with in1 as MSB.
- The output for row r is stored in tt[15-r], so row 0 lands in the hex MSB.
- dut_out passes through a 2-flop synchronizer; all sampling uses the synchronizer output (s_out).

FSM:
- **IDLE**:
  - On start: r←0, tt←0, pass←0, fail_row←0, settle counter←SETTLE_CYCLES, go to SETTLE.
  - Drives take row 0 on that same edge.
- **SETTLE**: decrement the counter each cycle; when it reaches 1, go to CAPTURE.
- **CAPTURE** (1 cycle):
  - Write the sample to tt[15-r].
  - If the sample differs from EXPECTED[15-r] and no mismatch has yet been recorded this sweep, fail_row←r.
  - If r==15, go to DONE.
  - Otherwise r←r+1, drives take the new row, counter←SETTLE_CYCLES, go to SETTLE.
- **DONE** (1 cycle):
  - done=1, pass←(tt==EXPECTED), drives←0.
  - Go to IDLE.

Rules:
- start during busy or DONE is ignored; it is not queued.
- tt, pass and fail_row hold their values in IDLE until the next accepted start.
- r does not wrap mid-sweep; the sweep ends after row 15.

Reset (rst_n low at a clk edge), including mid-sweep:
- State returns to IDLE.
- All outputs go to 0: drives, busy, done, tt, pass, fail_row.
- Counter, r and synchronizer flops are cleared.

## Timing
- An accepted start at edge E0 puts row 0 on the drives immediately after E0.
- Each row occupies SETTLE_CYCLES+1 cycles.
- CAPTURE of row r occurs in the cycle beginning at edge E0 + (r+1)(SETTLE_CYCLES+1) − 1.
- DONE is the cycle beginning at E0 + 16(SETTLE_CYCLES+1); with the default, that is E0+80.
- done and the final values of pass, tt and fail_row become visible together.
- Synchronizer latency is 2 cycles; SETTLE_CYCLES ≥ 3 guarantees the sample reflects the current row.

## Configuration
- **PROBER_MAJORITY_EN** defined:
  - The captured bit is the 2-of-3 majority of s_out over the last two SETTLE cycles and the CAPTURE cycle.
  - This suppresses a single-cycle glitch.
- Undefined: the captured bit is s_out in the CAPTURE cycle only.
- Latency is identical in both builds.

## Structure
- Package prober_pkg holds:
  - the state enum (IDLE, SETTLE, CAPTURE, DONE)
  - ROWS=16
  - the counter width constant (8)
  - the default expected table constant 16'h70EC
- One sub-module, prober_sync2: 2-flop synchronizer with synchronous active-low reset to 0.

## Test plan
- Behavioural model of 0x70EC, out = (in1&~in3) | (~in2&((in3&~in4)|(~in1&in4))), with default parameters:
  - start → done at E0+80, tt=16'h70EC, pass=1, fail_row=0.
- dut_out tied 0 → tt=16'h0000, pass=0, fail_row=1.
- start pulsed at E0+10 during a sweep → no effect and done still at E0+80.
  - A second start after done → tt clears to 0 the next cycle, then reads 16'h70EC at its done.
- rst_n low at the edge ending row 7's CAPTURE → all outputs 0 the next cycle.
  - A fresh start then restarts at row 0 and completes with tt=16'h70EC 80 cycles later.
- 1-cycle inverted glitch on s_out during row 0's CAPTURE cycle:
  - With PROBER_MAJORITY_EN: tt=16'h70EC, pass=1.
  - Without it: tt=16'hF0EC, pass=0, fail_row=0.

Source files
------------

// File: rtl/prober_pkg.sv
// Shared types and constants for the truth-table prober.
package prober_pkg;
  localparam int ROWS = 16;
  localparam int CNT_W = 8;
  localparam logic [15:0] EXPECTED_DEFAULT = 16'h70EC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;
endpackage

// File: rtl/prober_sync2.sv
// Two-flop synchronizer for the asynchronous circuit response; clears to 0 on reset.
module prober_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/truth_table_prober.sv
// Sweeps all 16 input rows of a 4-input circuit, captures its output into a hex truth table
// and compares it with EXPECTED. Define PROBER_MAJORITY_EN for 2-of-3 glitch-filtered sampling.
module truth_table_prober
  import prober_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [15:0] EXPECTED      = EXPECTED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dut_out,
  output logic        drive_in1,
  output logic        drive_in2,
  output logic        drive_in3,
  output logic        drive_in4,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        pass,
  output logic [3:0]  fail_row
);
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        row_q, row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       tt_q, tt_d;
  logic              pass_q, pass_d;
  logic [3:0]        fail_row_q, fail_row_d;
  logic              mism_q, mism_d;
  logic              s_out;
  logic              sample;
  logic [3:0]        bit_idx;

  prober_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out),
    .q     (s_out)
  );

`ifdef PROBER_MAJORITY_EN
  // s_out from the two preceding cycles, voted together with the current one
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) hist_q <= 2'b00;
    else        hist_q <= {hist_q[0], s_out};
  end

  assign sample = (s_out & hist_q[0]) | (s_out & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sample = s_out;
`endif

  // Row 0 lands in the MSB, so the table bit for row r is 15-r.
  assign bit_idx = ~row_q;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    tt_d       = tt_q;
    pass_d     = pass_q;
    fail_row_d = fail_row_q;
    mism_d     = mism_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETTLE;
          row_d      = 4'd0;
          cnt_d      = SETTLE_INIT;
          tt_d       = 16'h0000;
          pass_d     = 1'b0;
          fail_row_d = 4'd0;
          mism_d     = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(1)) state_d = CAPTURE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      CAPTURE: begin
        tt_d[bit_idx] = sample;
        if ((sample != EXPECTED[bit_idx]) && !mism_q) begin
          fail_row_d = row_q;
          mism_d     = 1'b1;
        end
        // pass resolves on the edge entering DONE so it appears together with done
        if (row_q == 4'd15) begin
          state_d = DONE;
          pass_d  = (tt_d == EXPECTED);
        end else begin
          state_d = SETTLE;
          row_d   = row_q + 4'd1;
          cnt_d   = SETTLE_INIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= 4'd0;
      cnt_q      <= '0;
      tt_q       <= 16'h0000;
      pass_q     <= 1'b0;
      fail_row_q <= 4'd0;
      mism_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      tt_q       <= tt_d;
      pass_q     <= pass_d;
      fail_row_q <= fail_row_d;
      mism_q     <= mism_d;
    end
  end

  assign busy = (state_q == SETTLE) || (state_q == CAPTURE);
  assign done = (state_q == DONE);
  // Drives follow the current row only while sweeping; zero in IDLE and DONE.
  assign {drive_in1, drive_in2, drive_in3, drive_in4} = busy ? row_q : 4'd0;
  assign tt       = tt_q;
  assign pass     = pass_q;
  assign fail_row = fail_row_q;
endmodule

// File: tb/tb_truth_table_prober.sv
// Directed and randomized bench for truth_table_prober with a behavioural circuit model.
module tb_truth_table_prober;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        dut_out;
  logic        drive_in1, drive_in2, drive_in3, drive_in4;
  logic        busy, done, pass;
  logic [15:0] tt;
  logic [3:0]  fail_row;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          mode;
  logic [15:0] rand_tbl;
  logic        glitch;
  logic [3:0]  idx;
  logic        model_out;

  localparam logic [15:0] GOLDEN = 16'h70EC;

  always #5 clk = ~clk;

  truth_table_prober dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dut_out   (dut_out),
    .drive_in1 (drive_in1),
    .drive_in2 (drive_in2),
    .drive_in3 (drive_in3),
    .drive_in4 (drive_in4),
    .busy      (busy),
    .done      (done),
    .tt        (tt),
    .pass      (pass),
    .fail_row  (fail_row)
  );

  function automatic logic circuit_fn(input logic a, input logic b, input logic c, input logic d);
    return (a & ~c) | (~b & ((c & ~d) | (~a & d)));
  endfunction

  function automatic logic responder(input int m, input logic [3:0] r, input logic [15:0] tbl);
    if (m == 0) return circuit_fn(r[3], r[2], r[1], r[0]);
    if (m == 1) return 1'b0;
    return tbl[15 - int'(r)];
  endfunction

  always_comb begin
    idx       = {drive_in1, drive_in2, drive_in3, drive_in4};
    model_out = responder(mode, idx, rand_tbl);
    dut_out   = model_out ^ glitch;
  end

  function automatic logic [15:0] expect_tt(input int m, input logic [15:0] tbl);
    logic [15:0] t;
    t = 16'h0000;
    for (int r = 0; r < 16; r++) t[15 - r] = responder(m, 4'(r), tbl);
    return t;
  endfunction

  function automatic logic [3:0] expect_fail_row(input logic [15:0] t);
    for (int r = 0; r < 16; r++)
      if (t[15 - r] != GOLDEN[15 - r]) return 4'(r);
    return 4'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sweep; pulse_at>0 pulses start mid-sweep, glitch_r0 inverts the sample seen in row 0's capture.
  task automatic run_sweep(input string tag, input int pulse_at, input bit glitch_r0,
                           input logic [15:0] exp_tt, input logic exp_pass, input logic [3:0] exp_fr);
    int lat;
    lat = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    chk({tag, "_tt_clear"}, 32'(tt), 32'd0);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == pulse_at)     start = 1'b1;
      if (k == pulse_at + 1) start = 1'b0;
      if (glitch_r0 && k == 2) glitch = 1'b1;
      if (k == 3)              glitch = 1'b0;
      if (k == 17) chk({tag, "_drv_row3"}, 32'(idx), 32'd3);
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'd80);
    chk({tag, "_tt"}, 32'(tt), 32'(exp_tt));
    chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    chk({tag, "_fail_row"}, 32'(fail_row), 32'(exp_fr));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'({done, busy}), 32'd0);
  endtask

  initial begin
    logic [15:0] e;
    int          lat;
    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = 0;
    rand_tbl = 16'h0000;
    glitch   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({drive_in1, drive_in2, drive_in3, drive_in4, busy, done, pass, fail_row, tt}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    e = expect_tt(0, rand_tbl);
    run_sweep("model", 0, 1'b0, e, e == GOLDEN, expect_fail_row(e));

    mode = 1;
    e = expect_tt(1, rand_tbl);
    run_sweep("tied0", 0, 1'b0, e, e == GOLDEN, expect_fail_row(e));
    chk("tied0_hold_tt", 32'(tt), 32'(e));

    mode = 0;
    e = expect_tt(0, rand_tbl);
    run_sweep("midstart", 10, 1'b0, e, 1'b1, 4'd0);
    run_sweep("second", 0, 1'b0, e, 1'b1, 4'd0);

    // Reset asserted so that it is sampled at the edge ending row 7's capture.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (39) @(negedge clk);
    chk("pre_rst_row7", 32'(idx), 32'd7);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outs", 32'({drive_in1, drive_in2, drive_in3, drive_in4, busy, done, pass, fail_row, tt}), 32'd0);
    rst_n = 1'b1;
    run_sweep("after_rst", 0, 1'b0, e, 1'b1, 4'd0);

`ifdef PROBER_MAJORITY_EN
    run_sweep("glitch", 0, 1'b1, GOLDEN, 1'b1, 4'd0);
`else
    run_sweep("glitch", 0, 1'b1, 16'hF0EC, 1'b0, 4'd0);
`endif

    mode = 2;
    for (int i = 0; i < 4; i++) begin
      rand_tbl = (i == 3) ? GOLDEN : 16'($urandom);
      e = expect_tt(2, rand_tbl);
      run_sweep("random", 0, 1'b0, e, e == GOLDEN, expect_fail_row(e));
    end

    // start is ignored while DONE is showing
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        start = 1'b1;
        break;
      end
    end
    chk("done_start_lat", 32'(lat), 32'd80);
    @(negedge clk) start = 1'b0;
    chk("done_start_ignored", 32'({busy, done}), 32'd0);
    @(negedge clk);
    chk("done_start_idle", 32'({busy, tt}), 32'(GOLDEN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
